// File: rtl/nibble_serial_adder_ctrl_if.sv
// Request/response bundle for the nibble-serial adder.
// The master side issues operations and accepts results; the slave side is the adder.
interface nibble_serial_adder_ctrl_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// W-bit add/subtract computed serially through one shared 4-bit ripple slice,
// one nibble per clock, LSB first, with valid/ready handshakes on both sides.
module nibble_serial_adder_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  nibble_serial_adder_ctrl_if.slave    bus
);
  localparam int W     = 4 * NIBBLES;
  localparam int CNT_W = $clog2(NIBBLES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_reg;
  logic [1:0]       state_next;
  logic [W-1:0]     op_a_reg;
  logic [W-1:0]     op_b_reg;
  logic             carry_reg;
  logic             ovf_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic             accept;
  logic             last_nibble;
  logic [3:0]       nib_a [NIBBLES];
  logic [3:0]       nib_b [NIBBLES];
  logic [3:0]       nib_sum_reg [NIBBLES];
  logic [3:0]       slice_x;
  logic [3:0]       slice_y;
  logic [3:0]       slice_s;
  logic [4:0]       slice_c;

  assign accept      = bus.in_valid && (state_reg == IDLE);
  assign last_nibble = (cnt_reg == LAST_CNT);

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.cout      = carry_reg;
  assign bus.ovf       = ovf_reg;

  // Split operands into nibbles and reassemble the result from its nibbles.
  for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
    assign nib_a[gi] = op_a_reg[gi*4 +: 4];
    assign nib_b[gi] = op_b_reg[gi*4 +: 4];
    assign bus.sum[gi*4 +: 4] = nib_sum_reg[gi];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        nib_sum_reg[gi] <= 4'd0;
      end else if ((state_reg == RUN) && (cnt_reg == CNT_W'(gi))) begin
        nib_sum_reg[gi] <= slice_s;
      end
    end
  end

  assign slice_x = nib_a[cnt_reg];
  assign slice_y = nib_b[cnt_reg];

  // The single shared 4-bit ripple-carry slice.
  assign slice_c[0] = carry_reg;
  for (genvar gi = 0; gi < 4; gi++) begin : g_slice
    assign slice_s[gi]   = slice_x[gi] ^ slice_y[gi] ^ slice_c[gi];
    assign slice_c[gi+1] = (slice_x[gi] & slice_y[gi]) |
                           (slice_c[gi] & (slice_x[gi] ^ slice_y[gi]));
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept)        state_next = RUN;
      RUN:     if (last_nibble)   state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Subtraction is A + ~B + 1: B is inverted at capture and the carry seeded with 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_reg  <= '0;
      op_b_reg  <= '0;
      carry_reg <= 1'b0;
      ovf_reg   <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            op_a_reg  <= bus.a;
            op_b_reg  <= bus.sub ? ~bus.b : bus.b;
            carry_reg <= bus.sub;
            cnt_reg   <= '0;
          end
        end
        RUN: begin
          carry_reg <= slice_c[4];
          cnt_reg   <= cnt_reg + 1'b1;
          if (last_nibble) begin
            ovf_reg <= (op_a_reg[W-1] == op_b_reg[W-1]) && (slice_s[3] != op_a_reg[W-1]);
          end
        end
        default: begin
        end
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Self-checking bench for nibble_serial_adder_ctrl: directed vectors, reset abort,
// backpressure, and a randomized run against a signed/unsigned arithmetic model.
module tb_nibble_serial_adder_ctrl;
  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;
  localparam int N_RAND  = 10000;
  localparam int CYCLE_LIMIT = 95000;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;

  nibble_serial_adder_ctrl_if #(.NIBBLES(NIBBLES)) bus ();

  nibble_serial_adder_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  // Result as {cout, ovf, sum} from plain integer arithmetic.
  function automatic logic [W+1:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic sub);
    longint ua, ub, sa, sb, r, lim;
    logic c, v;
    logic [W-1:0] s;
    lim = longint'(1) <<< (W - 1);
    ua  = longint'(a);
    ub  = longint'(b);
    sa  = (ua >= lim) ? ua - 2 * lim : ua;
    sb  = (ub >= lim) ? ub - 2 * lim : ub;
    if (sub) begin
      r = sa - sb;
      c = (ua >= ub);
      s = W'(ua - ub);
    end else begin
      r = sa + sb;
      c = ((ua + ub) >= 2 * lim);
      s = W'(ua + ub);
    end
    v = (r >= lim) || (r < -lim);
    return {c, v, s};
  endfunction

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input logic [W-1:0] exp_sum, input logic exp_cout,
                        input logic exp_ovf, input int stall);
    int n;
    check({tag, ".in_ready"}, 64'(bus.in_ready), 64'(1));
    bus.in_valid  = 1'b1;
    bus.a         = a;
    bus.b         = b;
    bus.sub       = sub;
    bus.out_ready = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    bus.a        = W'($urandom);
    bus.b        = W'($urandom);
    bus.sub      = 1'($urandom);
    n = 0;
    while (!bus.out_valid && n < 4 * NIBBLES) begin
      tick();
      n++;
    end
    check({tag, ".latency"}, 64'(n), 64'(NIBBLES));
    check({tag, ".sum"},  64'(bus.sum),  64'(exp_sum));
    check({tag, ".cout"}, 64'(bus.cout), 64'(exp_cout));
    check({tag, ".ovf"},  64'(bus.ovf),  64'(exp_ovf));
    for (int i = 0; i < stall; i++) begin
      bus.in_valid = 1'b1;
      bus.a        = W'($urandom);
      bus.b        = W'($urandom);
      tick();
      check({tag, ".stall_valid"}, 64'(bus.out_valid), 64'(1));
      check({tag, ".stall_ready"}, 64'(bus.in_ready),  64'(0));
      check({tag, ".stall_sum"},   64'(bus.sum),       64'(exp_sum));
      check({tag, ".stall_cout"},  64'(bus.cout),      64'(exp_cout));
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, ".hs_valid"}, 64'(bus.out_valid), 64'(0));
    check({tag, ".hs_ready"}, 64'(bus.in_ready),  64'(1));
    bus.in_valid = 1'b0;
    $display("op %s a=%h b=%h sub=%0d sum=%h cout=%0d ovf=%0d", tag, a, b, sub,
             bus.sum, bus.cout, bus.ovf);
  endtask

  initial begin
    logic [W+1:0] q[$];
    logic [W+1:0] exp;
    logic [W-1:0] ra, rb;
    logic         rs;
    int           accepted, done, acc_cycle;
    bit           seen;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    check("reset.in_ready",  64'(bus.in_ready),  64'(1));
    check("reset.out_valid", 64'(bus.out_valid), 64'(0));
    check("reset.sum",       64'(bus.sum),       64'(0));
    check("reset.cout",      64'(bus.cout),      64'(0));
    check("reset.ovf",       64'(bus.ovf),       64'(0));
    rst_n = 1'b1;
    tick();

    run_op("add",      16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0, 0);
    run_op("wrap",     16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 3);
    run_op("add_ovf",  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 0);
    run_op("sub",      16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1);
    run_op("sub_ovf",  16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 10);

    // Abort an operation two cycles into RUN.
    bus.in_valid = 1'b1;
    bus.a        = 16'h1111;
    bus.b        = 16'h2222;
    bus.sub      = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    repeat (2) tick();
    #2 rst_n = 1'b0;
    #1;
    check("rst_run.in_ready",  64'(bus.in_ready),  64'(1));
    check("rst_run.out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_run.sum",       64'(bus.sum),       64'(0));
    check("rst_run.cout",      64'(bus.cout),      64'(0));
    check("rst_run.ovf",       64'(bus.ovf),       64'(0));
    for (int i = 0; i < 6; i++) begin
      tick();
      check("rst_run.no_valid", 64'(bus.out_valid), 64'(0));
    end
    rst_n = 1'b1;
    run_op("after_rst", 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0, 0);

    // Randomized traffic with random consumer stalls.
    accepted  = 0;
    done      = 0;
    acc_cycle = 0;
    seen      = 1'b1;
    while (done < N_RAND && cycle < CYCLE_LIMIT) begin
      if (bus.out_valid && !seen) begin
        check("rand.latency", 64'(cycle - acc_cycle), 64'(NIBBLES));
        seen = 1'b1;
      end
      bus.out_ready = ($urandom_range(3) != 0);
      if (bus.out_valid && bus.out_ready) begin
        check("rand.have_expect", 64'(q.size() > 0), 64'(1));
        if (q.size() > 0) begin
          exp = q.pop_front();
          check("rand.sum",  64'(bus.sum),  64'(exp[W-1:0]));
          check("rand.cout", 64'(bus.cout), 64'(exp[W+1]));
          check("rand.ovf",  64'(bus.ovf),  64'(exp[W]));
          $display("rand %0d sum=%h cout=%0d ovf=%0d", done, bus.sum, bus.cout, bus.ovf);
        end
        done++;
      end
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom);
      if (bus.in_ready && accepted < N_RAND && $urandom_range(7) != 0) begin
        bus.in_valid = 1'b1;
        bus.a        = ra;
        bus.b        = rb;
        bus.sub      = rs;
        q.push_back(ref_model(ra, rb, rs));
        accepted++;
        acc_cycle = cycle + 1;
        seen      = 1'b0;
      end else if (!bus.in_ready) begin
        bus.in_valid = 1'($urandom);
        bus.a        = ra;
        bus.b        = rb;
        bus.sub      = rs;
      end else begin
        bus.in_valid = 1'b0;
      end
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("rand.completed", 64'(done), 64'(N_RAND));
    check("rand.queue_empty", 64'(q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
